qea_host_sequencer: RTL
=======================

# qea_host_sequencer

Host-side sequencer that drives one QEA instance through a full emulation run. It streams gate-context words into the CTX RAM and initialises the state RAM to |0…0⟩. It then pulses start, waits for completion with a cycle counter and timeout, and streams the final state vector back out. It sits between the host/DMA interface and the QEA top, replacing hand-sequenced stimulus.

## Interface
- PE_NUM_WIDTH, 2, log2 of PE count
- PE_NUM, 4, PEs per state word
- STATE_DATA_WIDTH, 64, one complex amplitude (re, im Q2.30)
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 64, ctx word width
- GATE_CONTEXT_ADDR_WIDTH, 16, ctx RAM address width
- MAX_QBIT_WIDTH, 6, qubit-count width
- AMP_ONE, 64'h40000000_00000000, amplitude 1.0+0j
- RD_LATENCY, 1, cycles from state-RAM read address to o_state_dout valid
- TIMEOUT_WIDTH, 32, timeout/cycle counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_run  in  1  one-cycle run request; ignored unless IDLE
- i_abort  in  1  return to IDLE from any state
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_run
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  ctx words to load, latched on i_run
- i_timeout  in  TIMEOUT_WIDTH  max WAIT cycles; 0 = no timeout
- i_ctx_valid / o_ctx_ready  in/out  1  ctx stream handshake
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  ctx stream word
- o_qea_start  out  1  start pulse to QEA
- o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count to QEA
- o_ctx_en, o_ctx_wea  out  1  CTX RAM strobes
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH; o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH
- o_state_ena, o_state_wea  out  1  state RAM strobes
- o_state_addra  out  STATE_ADDR_WIDTH; o_state_dina  out  PE_NUM*STATE_DATA_WIDTH
- i_qea_complete  in  1  QEA completion level
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  QEA state read data
- o_res_valid  out  1; o_res_addr  out  STATE_ADDR_WIDTH; o_res_data  out  PE_NUM*STATE_DATA_WIDTH  readout stream, no backpressure
- o_busy  out  1  not IDLE
- o_done  out  1  one-cycle pulse at end of run
- o_error  out  1  sticky until next accepted i_run: bad qbit_num or timeout
- o_cycles  out  TIMEOUT_WIDTH  cycles from start pulse to complete

## Operation
- States: IDLE → LOAD_CTX → LOAD_STATE → START → WAIT → READ → DRAIN → IDLE. ERR is transient and returns to IDLE.
- IDLE, i_run: latch inputs and clear o_error and o_cycles.
  - Legal qbit_num: PE_NUM_WIDTH ≤ q ≤ STATE_ADDR_WIDTH+PE_NUM_WIDTH. Otherwise set o_error, pulse o_done, stay IDLE.
  - Legal run with i_ins_num=0: go directly to LOAD_STATE. Otherwise go to LOAD_CTX.
- LOAD_CTX: o_ctx_ready=1.
  - Each i_ctx_valid&o_ctx_ready beat issues one write: o_ctx_en=o_ctx_wea=1, address = beat index from 0, data = i_ctx_data, registered.
  - After beat i_ins_num-1, go to LOAD_STATE.
- LOAD_STATE: writes N=2**(q-PE_NUM_WIDTH) words at addresses 0..N-1, one per cycle, ena=wea=1.
  - Word 0 = {AMP_ONE, 0…} (AMP_ONE in the top STATE_DATA_WIDTH slot).
  - All other words are 0.
- START: o_qea_start=1 for exactly one cycle; o_cycles counter starts at 1.
- WAIT: i_qea_complete is not sampled in the START cycle; it is sampled from the next cycle.
  - o_cycles increments each cycle until complete is seen, then freezes.
  - If i_timeout≠0 and o_cycles reaches i_timeout: set o_error, pulse o_done, go IDLE.
- READ: issue N reads (ena=1, wea=0) at addresses 0..N-1, one per cycle.
- DRAIN: wait RD_LATENCY cycles.
  - Readout data appears on o_res_valid/o_res_addr/o_res_data exactly RD_LATENCY cycles after each read address, via a shift pipeline carrying valid and addr.
  - After the last result: pulse o_done, go IDLE.
- i_abort: next state is IDLE and all strobes deassert the following cycle. The readout pipeline is flushed and o_error is unchanged.
- Counters: the address counter is STATE_ADDR_WIDTH+1 bits wide, so N=2**STATE_ADDR_WIDTH terminates without wrap. o_cycles saturates at all-ones.

## Timing
- All outputs are registered.
- Reset values: every strobe, o_busy, o_done, o_error, o_res_valid = 0; every address/data/o_cycles/o_qbit_num = 0; state = IDLE.
- Throughput:
  - Ctx writes: one per accepted beat; the write is visible 1 cycle after acceptance.
  - State writes and reads: one per cycle with no bubbles.
- Phase transitions take 1 cycle each: LOAD_CTX→LOAD_STATE, LOAD_STATE→START, START→WAIT, WAIT→READ.
- A run with i_run and i_abort in the same cycle is not accepted.
- rst mid-run: all outputs return to reset values the next cycle. QEA state is not cleared.

## Test plan
- 11 qubits, i_ins_num=359, ctx stream valid every cycle, QEA model completes 1000 cycles after start → 359 ctx writes at addresses 0..358; 512 state writes with word 0 top slot 0x40000000_00000000; o_cycles=1001; 512 o_res beats at addresses 0..511; o_done once.
- Ctx stream with random i_ctx_valid gaps, i_ins_num=5 → exactly 5 writes at contiguous addresses 0..4 with data order preserved.
- i_qbit_num=1 and i_qbit_num=19 (PE_NUM_WIDTH=2, STATE_ADDR_WIDTH=16) → no RAM strobes; o_error=1; o_done pulses the cycle after i_run.
- i_timeout=50, complete never asserts → o_error=1 and o_done pulse when o_cycles=50; no reads issued.
- RD_LATENCY=3, 2 qubits (N=1) → single read; o_res_valid 3 cycles later with addr 0.
- i_abort in the middle of LOAD_STATE, and separately rst in WAIT → all strobes 0 next cycle, o_busy=0; a new i_run completes normally.

Source files
------------

// File: rtl/qea_host_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qea_host_sequencer: loads ctx/state RAMs, starts one QEA run, streams result. Rev 1.0
// ----------------------------------------------------------------------------
module qea_host_sequencer #(
    parameter int                        PE_NUM_WIDTH            = 2,
    parameter int                        PE_NUM                  = 4,
    parameter int                        STATE_DATA_WIDTH        = 64,
    parameter int                        STATE_ADDR_WIDTH        = 16,
    parameter int                        GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int                        GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int                        MAX_QBIT_WIDTH          = 6,
    parameter logic [STATE_DATA_WIDTH-1:0] AMP_ONE               = 64'h40000000_00000000,
    parameter int                        RD_LATENCY              = 1,
    parameter int                        TIMEOUT_WIDTH           = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_run,
    input  logic                                   i_abort,
    input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     i_ins_num,
    input  logic [TIMEOUT_WIDTH-1:0]               i_timeout,
    input  logic                                   i_ctx_valid,
    output logic                                   o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]     i_ctx_data,
    output logic                                   o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]              o_qbit_num,
    output logic                                   o_ctx_en,
    output logic                                   o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]     o_ctx_data,
    output logic                                   o_state_ena,
    output logic                                   o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_state_dina,
    input  logic                                   i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
    output logic                                   o_res_valid,
    output logic [STATE_ADDR_WIDTH-1:0]            o_res_addr,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_res_data,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_error,
    output logic [TIMEOUT_WIDTH-1:0]               o_cycles
);

    localparam int CW = STATE_ADDR_WIDTH + 1;
    localparam int WW = PE_NUM * STATE_DATA_WIDTH;
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    localparam logic [WW-1:0] INIT_WORD = {AMP_ONE, {(WW-STATE_DATA_WIDTH){1'b0}}};
    localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_CTX   = 3'd1,
        S_LOAD_STATE = 3'd2,
        S_START      = 3'd3,
        S_WAIT       = 3'd4,
        S_READ       = 3'd5,
        S_DRAIN      = 3'd6
    } state_e;

    state_e                               state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q, qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q, ins_d;
    logic [TIMEOUT_WIDTH-1:0]             timeout_q, timeout_d;
    logic [CW-1:0]                        n_last_q, n_last_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_q, ctx_cnt_d;
    logic                                 ctx_ready_q, ctx_ready_d;
    logic                                 ctx_en_q, ctx_en_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q, ctx_addr_d;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q, ctx_data_d;
    logic                                 start_q, start_d;
    logic                                 st_ena_q, st_ena_d;
    logic                                 st_wea_q, st_wea_d;
    logic [STATE_ADDR_WIDTH-1:0]          st_addr_q, st_addr_d;
    logic [WW-1:0]                        st_din_q, st_din_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic                                 error_q, error_d;
    logic [TIMEOUT_WIDTH-1:0]             cycles_q, cycles_d;

    logic                                 w_qbit_legal;
    logic [CW-1:0]                        w_n_last;
    logic [TIMEOUT_WIDTH-1:0]             w_cycles_inc;

    logic [RD_LATENCY-1:0]                res_vld_q;
    logic [STATE_ADDR_WIDTH-1:0]          res_addr_q [RD_LATENCY];

    assign w_qbit_legal = (i_qbit_num >= QBIT_MIN) && (i_qbit_num <= QBIT_MAX);
    assign w_n_last     = (CW'(1) << (i_qbit_num - QBIT_MIN)) - CW'(1);
    assign w_cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        qbit_d      = qbit_q;
        ins_d       = ins_q;
        timeout_d   = timeout_q;
        n_last_d    = n_last_q;
        cnt_d       = cnt_q;
        ctx_cnt_d   = ctx_cnt_q;
        ctx_en_d    = 1'b0;
        ctx_addr_d  = ctx_addr_q;
        ctx_data_d  = ctx_data_q;
        start_d     = 1'b0;
        st_ena_d    = 1'b0;
        st_wea_d    = 1'b0;
        st_addr_d   = st_addr_q;
        st_din_d    = st_din_q;
        done_d      = 1'b0;
        error_d     = error_q;
        cycles_d    = cycles_q;

        case (state_q)
            S_IDLE: begin
                if (i_run && !i_abort) begin
                    qbit_d    = i_qbit_num;
                    ins_d     = i_ins_num;
                    timeout_d = i_timeout;
                    n_last_d  = w_n_last;
                    cnt_d     = '0;
                    ctx_cnt_d = '0;
                    cycles_d  = '0;
                    error_d   = 1'b0;
                    if (!w_qbit_legal) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else if (i_ins_num == '0) begin
                        state_d = S_LOAD_STATE;
                    end else begin
                        state_d = S_LOAD_CTX;
                    end
                end
            end
            S_LOAD_CTX: begin
                if (i_ctx_valid && ctx_ready_q) begin
                    ctx_en_d   = 1'b1;
                    ctx_addr_d = ctx_cnt_q;
                    ctx_data_d = i_ctx_data;
                    ctx_cnt_d  = ctx_cnt_q + 1'b1;
                    if (ctx_cnt_q == ins_q - 1'b1) begin
                        state_d = S_LOAD_STATE;
                    end
                end
            end
            S_LOAD_STATE: begin
                st_ena_d  = 1'b1;
                st_wea_d  = 1'b1;
                st_addr_d = cnt_q[STATE_ADDR_WIDTH-1:0];
                st_din_d  = (cnt_q == '0) ? INIT_WORD : '0;
                if (cnt_q == n_last_q) begin
                    cnt_d    = '0;
                    state_d  = S_START;
                    start_d  = 1'b1;
                    cycles_d = TIMEOUT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                // completion is deliberately not looked at in the start-pulse cycle
                state_d  = S_WAIT;
                cycles_d = w_cycles_inc;
            end
            S_WAIT: begin
                if (i_qea_complete) begin
                    state_d = S_READ;
                end else if ((timeout_q != '0) && (cycles_q >= timeout_q)) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cycles_d = w_cycles_inc;
                end
            end
            S_READ: begin
                st_ena_d  = 1'b1;
                st_addr_d = cnt_q[STATE_ADDR_WIDTH-1:0];
                if (cnt_q == n_last_q) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // done lines up with the last result leaving the read pipeline
                if (cnt_q == DRAIN_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_abort) begin
            state_d  = S_IDLE;
            ctx_en_d = 1'b0;
            start_d  = 1'b0;
            st_ena_d = 1'b0;
            st_wea_d = 1'b0;
            done_d   = 1'b0;
            error_d  = error_q;
        end

        ctx_ready_d = (state_d == S_LOAD_CTX);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            qbit_q      <= '0;
            ins_q       <= '0;
            timeout_q   <= '0;
            n_last_q    <= '0;
            cnt_q       <= '0;
            ctx_cnt_q   <= '0;
            ctx_ready_q <= 1'b0;
            ctx_en_q    <= 1'b0;
            ctx_addr_q  <= '0;
            ctx_data_q  <= '0;
            start_q     <= 1'b0;
            st_ena_q    <= 1'b0;
            st_wea_q    <= 1'b0;
            st_addr_q   <= '0;
            st_din_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            qbit_q      <= qbit_d;
            ins_q       <= ins_d;
            timeout_q   <= timeout_d;
            n_last_q    <= n_last_d;
            cnt_q       <= cnt_d;
            ctx_cnt_q   <= ctx_cnt_d;
            ctx_ready_q <= ctx_ready_d;
            ctx_en_q    <= ctx_en_d;
            ctx_addr_q  <= ctx_addr_d;
            ctx_data_q  <= ctx_data_d;
            start_q     <= start_d;
            st_ena_q    <= st_ena_d;
            st_wea_q    <= st_wea_d;
            st_addr_q   <= st_addr_d;
            st_din_q    <= st_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cycles_q    <= cycles_d;
        end
    end

    // read-issue tracker: valid/addr follow each read address by RD_LATENCY cycles
    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            res_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                res_addr_q[i] <= '0;
            end
        end else begin
            res_vld_q[0]  <= st_ena_q & ~st_wea_q;
            res_addr_q[0] <= st_addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                res_vld_q[i]  <= res_vld_q[i-1];
                res_addr_q[i] <= res_addr_q[i-1];
            end
        end
    end

    assign o_ctx_ready   = ctx_ready_q;
    assign o_qea_start   = start_q;
    assign o_qbit_num    = qbit_q;
    assign o_ctx_en      = ctx_en_q;
    assign o_ctx_wea     = ctx_en_q;
    assign o_ctx_addr    = ctx_addr_q;
    assign o_ctx_data    = ctx_data_q;
    assign o_state_ena   = st_ena_q;
    assign o_state_wea   = st_wea_q;
    assign o_state_addra = st_addr_q;
    assign o_state_dina  = st_din_q;
    assign o_res_valid   = res_vld_q[RD_LATENCY-1];
    assign o_res_addr    = res_addr_q[RD_LATENCY-1];
    // RAM output is already registered; gating keeps it at zero outside valid beats
    assign o_res_data    = res_vld_q[RD_LATENCY-1] ? i_state_dout : '0;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_cycles      = cycles_q;

endmodule
`default_nettype wire
